// File: rtl/outputconditioner_pkg.sv
// Shared FSM state encodings for the output conditioner.
// OC_BOUNCE exists only when OUTPUTCONDITIONER_BOUNCE_EN is defined.
package outputconditioner_pkg;

  typedef enum logic [1:0] {
    OC_IDLE   = 2'd0,
    OC_HOLD   = 2'd1
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
    ,
    OC_BOUNCE = 2'd2
`endif
  } oc_state_t;

endpackage

// File: rtl/outputconditioner_levelfifo.sv
// 1-bit synchronous request FIFO, head visible combinationally; push refused when full
// (even with a simultaneous pop), pop ignored when empty.
module outputconditioner_levelfifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_level,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_level;
  end

endmodule

// File: rtl/outputconditioner.sv
// Pin driver: queued levels are driven one per transition, each held >= HOLD cycles; latency 1 cycle
// from accept to pin change; req_ready = !full. Optional bounce emulation: OUTPUTCONDITIONER_BOUNCE_EN.
module outputconditioner
  import outputconditioner_pkg::*;
#(
  parameter int   T      = 4,
  parameter int   HOLD   = T + 4,
  parameter int   DEPTH  = 4,
  parameter int   BOUNCE = 3,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic pin,
  output logic edge_out,
  output logic busy
);

  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  // Unsupported parameter sets elaborate this marker block.
  if (HOLD < 2 || DEPTH < 2 || BOUNCE < 0) begin : g_bad_cfg
  end

  oc_state_t     state;
  oc_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          pin_nxt;
  logic          edge_nxt;
  logic          pop;
  logic          start;
  logic          full;
  logic          empty;
  logic          head;

`ifdef OUTPUTCONDITIONER_BOUNCE_EN
  localparam int            BW      = $clog2(2 * BOUNCE + 1);
  localparam logic [BW-1:0] BRELOAD = BW'(2 * BOUNCE - 1);
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_nxt;
  logic          tgt;
  logic          tgt_nxt;
`endif

  assign req_ready = !full;
  assign busy      = (state != OC_IDLE) || !empty;

  outputconditioner_levelfifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid && req_ready),
    .push_level(req_level),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pin_nxt   = pin;
    edge_nxt  = 1'b0;
    pop       = 1'b0;
    start     = 1'b0;
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
    bcnt_nxt  = bcnt;
    tgt_nxt   = tgt;
`endif
    case (state)
      OC_IDLE: begin
        // Same-level entries are popped and dropped without disturbing the pin.
        if (!empty) begin
          pop   = 1'b1;
          start = (head != pin);
        end
      end
      OC_HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!empty && (head != pin)) begin
          pop   = 1'b1;
          start = 1'b1;
        end else begin
          state_nxt = OC_IDLE;
        end
      end
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
      OC_BOUNCE: begin
        if (bcnt != '0) begin
          bcnt_nxt = bcnt - BW'(1);
          pin_nxt  = !pin;
        end else begin
          pin_nxt   = tgt;
          cnt_nxt   = RELOAD;
          state_nxt = OC_HOLD;
        end
      end
`endif
      default: state_nxt = OC_IDLE;
    endcase

    if (start) begin
      pin_nxt  = head;
      edge_nxt = 1'b1;
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
      tgt_nxt   = head;
      bcnt_nxt  = BRELOAD;
      state_nxt = OC_BOUNCE;
`else
      cnt_nxt   = RELOAD;
      state_nxt = OC_HOLD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OC_IDLE;
      cnt      <= '0;
      pin      <= INIT;
      edge_out <= 1'b0;
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
      bcnt     <= '0;
      tgt      <= INIT;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pin      <= pin_nxt;
      edge_out <= edge_nxt;
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
      bcnt     <= bcnt_nxt;
      tgt      <= tgt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_outputconditioner.sv
// Randomized bench for outputconditioner against a transition-timing reference model.
module tb_outputconditioner;

  localparam int   T      = 4;
  localparam int   HOLD   = T + 4;
  localparam int   DEPTH  = 4;
  localparam int   BOUNCE = 3;
  localparam logic INIT   = 1'b0;
`ifdef OUTPUTCONDITIONER_BOUNCE_EN
  localparam int   BNC    = 2 * BOUNCE;
`else
  localparam int   BNC    = 0;
`endif
  localparam int   PER    = BNC + HOLD;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic req_valid = 1'b0;
  logic req_level = 1'b0;
  logic req_ready;
  logic pin;
  logic edge_out;
  logic busy;

  outputconditioner #(
    .T(T), .HOLD(HOLD), .DEPTH(DEPTH), .BOUNCE(BOUNCE), .INIT(INIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_level(req_level),
    .req_ready(req_ready),
    .pin      (pin),
    .edge_out (edge_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int edges = 0;

  // Model: queue of accepted levels, the settled level, and the edge index of the last transition.
  logic mq[$];
  logic m_tgt  = INIT;
  logic m_old  = INIT;
  int   m_last = -1000;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int   pre;
    logic lv;
    pre = mq.size();
    if (!rst_n) begin
      mq.delete();
      m_tgt  = INIT;
      m_old  = INIT;
      m_last = -1000;
    end else begin
      if (cyc == m_last + PER) begin
        if (mq.size() > 0 && mq[0] != m_tgt) begin
          m_old  = m_tgt;
          m_tgt  = mq.pop_front();
          m_last = cyc;
        end
      end else if (cyc > m_last + PER && mq.size() > 0) begin
        lv = mq.pop_front();
        if (lv != m_tgt) begin
          m_old  = m_tgt;
          m_tgt  = lv;
          m_last = cyc;
        end
      end
      if (req_valid && pre < DEPTH) mq.push_back(req_level);
    end
  endtask

  function automatic logic exp_pin();
    int d;
    d = cyc - m_last;
    if (d < BNC) return (d % 2 == 0) ? m_tgt : m_old;
    return m_tgt;
  endfunction

  task automatic step(input logic v, input logic lv, input logic r);
    req_valid = v;
    req_level = lv;
    rst_n     = r;
    @(posedge clk);
    model_edge();
    #1;
    check("pin",       int'(pin),       int'(exp_pin()));
    check("edge_out",  int'(edge_out),  int'(m_last == cyc));
    check("req_ready", int'(req_ready), int'(mq.size() < DEPTH));
    check("busy",      int'(busy),      int'((cyc < m_last + PER) || (mq.size() > 0)));
    if (edge_out) edges++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic seq[3];
    do_reset();
    check("reset_pin", int'(pin), int'(INIT));
    check("reset_ready", int'(req_ready), 1);
    check("reset_busy", int'(busy), 0);

    // Single rising request, then let the hold expire.
    step(1'b1, 1'b1, 1'b1);
    idle(PER + 4);
    check("single_busy_done", int'(busy), 0);

    // Back-to-back 1,0,1 from pin 0: three transitions, PER cycles apart.
    do_reset();
    edges = 0;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, seq[i], 1'b1);
    idle(3 * PER + 4);
    check("b2b_edge_count", edges, 3);

    // Fill during a hold: fifth alternating push must be refused.
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, logic'(i % 2 == 0 ? 0 : 1), 1'b1);
    check("fill_ready_low", int'(req_ready), 0);
    idle(6 * PER);

    // Same-level request is dropped without an edge.
    do_reset();
    edges = 0;
    step(1'b1, 1'b0, 1'b1);
    idle(3);
    check("same_level_edges", edges, 0);

    // Reset in the third cycle of a hold with entries queued.
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("rst_mid_pin", int'(pin), int'(INIT));
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_edge", int'(edge_out), 0);
    idle(PER + 2);

    // Random traffic in bursts of varying density, with occasional resets.
    for (int b = 0; b < 40; b++) begin
      int dens;
      dens = $urandom_range(5, 95);
      for (int i = 0; i < 80; i++) begin
        step(logic'($urandom_range(0, 99) < dens), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 299) != 0));
      end
    end
    idle(DEPTH * PER + 4);
    check("final_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
